xor_arbiter: RTL

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/xor_arbiter.sv
// xor_arbiter: four requesters share one registered XOR datapath.
// A round-robin pick in IDLE latches the winner's operands and pulses gnt
// (EXEC), and then the result is held in RESULT until the consumer takes it.
// Optional feature: define XOR_ARB_PARITY_EN to add the y_par output, which is
// the registered XOR-reduction of y.
module xor_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] a_in,
    input  logic [4*W-1:0] b_in,
    output logic [3:0]     gnt,
    output logic [W-1:0]   y,
    output logic           y_valid,
    output logic [1:0]     y_id,
    input  logic           y_ready
`ifdef XOR_ARB_PARITY_EN
    ,
    output logic           y_par
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]   state;
    logic [1:0]   ptr;
    logic [1:0]   win;
    logic [W-1:0] a_lat;
    logic [W-1:0] b_lat;

    logic [W-1:0] a_arr [4];
    logic [W-1:0] b_arr [4];
    logic         found;
    logic [1:0]   pick;
    logic [1:0]   idx;

    // Split the flat operand buses into per-requester slices.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            a_arr[i] = a_in[i*W +: W];
            b_arr[i] = b_in[i*W +: W];
        end
    end

    // Round-robin search: the first set req bit starting at ptr, wrapping 3 to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // FSM and datapath registers. y and y_id keep their values after a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            gnt     <= '0;
            y       <= '0;
            y_id    <= '0;
            y_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_lat <= a_arr[pick];
                        b_lat <= b_arr[pick];
                        win   <= pick;
                        gnt   <= 4'b0001 << pick;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    y       <= a_lat ^ b_lat;
                    y_id    <= win;
                    y_valid <= 1'b1;
                    gnt     <= '0;
                    state   <= RESULT;
                end
                RESULT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        ptr     <= win + 2'd1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt     <= '0;
                    y_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef XOR_ARB_PARITY_EN
    // The parity register loads on the same edge as y, so it holds whenever y holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_par <= 1'b0;
        end else if (state == EXEC) begin
            y_par <= ^(a_lat ^ b_lat);
        end
    end
`endif

endmodule
